// File: rtl/corejtagdebug_scan_engine_if.sv
// Command/response handshake between a scan sequencer and the JTAG scan engine.
// The sequencer side uses the master modport and the engine uses the slave modport.
interface corejtagdebug_scan_engine_if #(
    parameter int MAX_DR_LEN = 64,
    parameter int LEN_W      = 7
);
    logic                  CMD_VALID;
    logic                  CMD_READY;
    logic [1:0]            CMD_TYPE;
    logic [LEN_W-1:0]      CMD_LEN;
    logic [MAX_DR_LEN-1:0] CMD_DATA;
    logic                  RSP_VALID;
    logic [MAX_DR_LEN-1:0] RSP_DATA;
    logic                  RSP_ERR;
    logic                  BUSY;

    modport master (
        output CMD_VALID, CMD_TYPE, CMD_LEN, CMD_DATA,
        input  CMD_READY, RSP_VALID, RSP_DATA, RSP_ERR, BUSY
    );

    modport slave (
        input  CMD_VALID, CMD_TYPE, CMD_LEN, CMD_DATA,
        output CMD_READY, RSP_VALID, RSP_DATA, RSP_ERR, BUSY
    );
endinterface

// File: rtl/corejtagdebug_scan_engine.sv
// Command-driven JTAG scan engine: turns TAP-reset / IR / DR / idle commands into
// registered TMS/TDO sequences and returns the TDI bits captured while shifting.
//
// state    | meaning
// INIT_RST | driving TMS=1 (auto reset after TRST, or TAP-reset command)
// IDLE     | waiting for a command, TMS=0
// SEL_DR   | first TMS=1 of a scan
// SEL_IR   | second TMS=1 of an IR scan
// CAPTURE  | two TMS=0 cycles leading into the shift
// SHIFT    | shifting data, TMS=1 on the last bit
// EXIT1    | TMS=1 towards Update
// UPDATE   | TMS=0 back to Run-Test/Idle
// RTI_WAIT | TMS=0 idle cycles, or the TMS=0 tail of a TAP reset
// RESP     | response pulse, next command may be accepted
module corejtagdebug_scan_engine #(
    parameter int MAX_IR_LEN = 8,
    parameter int MAX_DR_LEN = 64,
    parameter int LEN_W      = 7
) (
    input  logic                       TCK,
    input  logic                       TRST,
    corejtagdebug_scan_engine_if.slave bus,
    output logic                       TMS,
    output logic                       TDO,
    input  logic                       TDI
);
    typedef enum logic [3:0] {
        INIT_RST, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RTI_WAIT, RESP
    } state_t;

    localparam logic [1:0]       CMD_TAP_RST = 2'b00;
    localparam logic [1:0]       CMD_IR      = 2'b01;
    localparam logic [1:0]       CMD_DR      = 2'b10;
    localparam logic [LEN_W-1:0] MAX_IR_L    = LEN_W'(MAX_IR_LEN);
    localparam logic [LEN_W-1:0] MAX_DR_L    = LEN_W'(MAX_DR_LEN);
    localparam logic [LEN_W-1:0] RST_CNT     = LEN_W'(4);
    localparam logic [LEN_W-1:0] ONE         = LEN_W'(1);

    state_t                state_q, state_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  is_ir_q, is_ir_d;
    logic                  resp_pend_q, resp_pend_d;
    logic [MAX_DR_LEN-1:0] sr_q, sr_d;
    logic [MAX_DR_LEN-1:0] cap_q, cap_d;
    logic [MAX_DR_LEN-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  ready_q, ready_d;
    logic                  tms_q, tms_d;
    logic                  tdo_q, tdo_d;
    logic                  accept;
    logic                  scan_err;

    assign accept   = bus.CMD_VALID && ready_q;
    assign scan_err = (bus.CMD_LEN == '0) ||
                      ((bus.CMD_TYPE == CMD_IR) ? (bus.CMD_LEN > MAX_IR_L)
                                                : (bus.CMD_LEN > MAX_DR_L));

    always_ff @(posedge TCK) begin
        if (TRST) begin
            state_q     <= INIT_RST;
            cnt_q       <= RST_CNT;
            len_q       <= '0;
            is_ir_q     <= 1'b0;
            resp_pend_q <= 1'b0;
            sr_q        <= '0;
            cap_q       <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            tms_q       <= 1'b1;
            tdo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            is_ir_q     <= is_ir_d;
            resp_pend_q <= resp_pend_d;
            sr_q        <= sr_d;
            cap_q       <= cap_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            ready_q     <= ready_d;
            tms_q       <= tms_d;
            tdo_q       <= tdo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        is_ir_d     = is_ir_q;
        resp_pend_d = resp_pend_q;
        sr_d        = sr_q;
        cap_d       = cap_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            INIT_RST: begin
                if (cnt_q == '0) state_d = RTI_WAIT;
                else             cnt_d   = cnt_q - ONE;
            end
            RTI_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                end else if (resp_pend_q) begin
                    state_d    = RESP;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            IDLE, RESP: begin
                if (state_q == RESP) state_d = IDLE;
                if (accept) begin
                    is_ir_d     = (bus.CMD_TYPE == CMD_IR);
                    len_d       = bus.CMD_LEN;
                    sr_d        = bus.CMD_DATA;
                    cap_d       = '0;
                    resp_pend_d = 1'b1;
                    case (bus.CMD_TYPE)
                        CMD_TAP_RST: begin
                            state_d = INIT_RST;
                            cnt_d   = RST_CNT;
                        end
                        CMD_IR, CMD_DR: begin
                            if (scan_err) begin
                                state_d    = RESP;
                                rsp_data_d = '0;
                                rsp_err_d  = 1'b1;
                            end else begin
                                state_d = SEL_DR;
                            end
                        end
                        default: begin
                            if (bus.CMD_LEN == '0) begin
                                state_d    = RESP;
                                rsp_data_d = '0;
                                rsp_err_d  = 1'b0;
                            end else begin
                                state_d = RTI_WAIT;
                                cnt_d   = bus.CMD_LEN - ONE;
                            end
                        end
                    endcase
                end
            end
            SEL_DR: begin
                state_d = is_ir_q ? SEL_IR : CAPTURE;
                cnt_d   = ONE;
            end
            SEL_IR: begin
                state_d = CAPTURE;
                cnt_d   = ONE;
            end
            CAPTURE: begin
                if (cnt_q == '0) begin
                    state_d = SHIFT;
                    cnt_d   = len_q - ONE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            SHIFT: begin
                // TDI enters at the top; UPDATE right-aligns by the scan length
                sr_d  = sr_q >> 1;
                cap_d = MAX_DR_LEN'({TDI, cap_q} >> 1);
                if (cnt_q == '0) state_d = EXIT1;
                else             cnt_d   = cnt_q - ONE;
            end
            EXIT1:   state_d = UPDATE;
            UPDATE: begin
                state_d    = RESP;
                rsp_data_d = cap_q >> (MAX_DR_LEN - int'(len_q));
                rsp_err_d  = 1'b0;
            end
            default: state_d = INIT_RST;
        endcase
    end

    // Pin values are decoded from the next state so TMS/TDO leave flops directly
    always_comb begin
        tms_d = 1'b0;
        tdo_d = 1'b0;
        case (state_d)
            INIT_RST, SEL_DR, SEL_IR, EXIT1: tms_d = 1'b1;
            SHIFT: begin
                tms_d = (cnt_d == '0);
                tdo_d = sr_d[0];
            end
            default: ;
        endcase
        ready_d     = (state_d == IDLE) || (state_d == RESP);
        rsp_valid_d = (state_d == RESP);
    end

    assign bus.CMD_READY = ready_q;
    assign bus.BUSY      = ~ready_q;
    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_DATA  = rsp_data_q;
    assign bus.RSP_ERR   = rsp_err_q;
    assign TMS           = tms_q;
    assign TDO           = tdo_q;
endmodule

// File: tb/tb_corejtagdebug_scan_engine.sv
// Bench for the JTAG scan engine: expected TMS/TDO streams and responses are built
// from the command rules; target TDI bits are scheduled onto the expected shift cycles.
module tb_corejtagdebug_scan_engine;
    localparam int MAX_IR_LEN = 8;
    localparam int MAX_DR_LEN = 64;
    localparam int LEN_W      = 7;

    logic tck  = 1'b0;
    logic trst = 1'b1;
    logic tdi  = 1'b0;
    logic tms, tdo;

    int          checks = 0;
    int          errors = 0;
    bit          last_known = 1'b0;
    logic [63:0] last_exp = '0;

    corejtagdebug_scan_engine_if #(.MAX_DR_LEN(MAX_DR_LEN), .LEN_W(LEN_W)) bus ();

    corejtagdebug_scan_engine #(
        .MAX_IR_LEN(MAX_IR_LEN), .MAX_DR_LEN(MAX_DR_LEN), .LEN_W(LEN_W)
    ) dut (
        .TCK(tck), .TRST(trst), .bus(bus), .TMS(tms), .TDO(tdo), .TDI(tdi)
    );

    always #5 tck = ~tck;

    // Entered at a negedge; holds TRST for hold_cycles edges, then checks the auto reset walk.
    task automatic do_reset(input int hold_cycles);
        trst = 1'b1;
        repeat (hold_cycles) @(posedge tck);
        #1;
        checks++;
        if (tms !== 1'b1 || tdo !== 1'b0 || bus.CMD_READY !== 1'b0 || bus.BUSY !== 1'b1 ||
            bus.RSP_VALID !== 1'b0 || bus.RSP_ERR !== 1'b0 || bus.RSP_DATA !== 64'd0) begin
            errors++;
            $display("FAIL reset_values: tms=%b tdo=%b rdy=%b busy=%b rv=%b err=%b data=%h, need 1 0 0 1 0 0 0",
                     tms, tdo, bus.CMD_READY, bus.BUSY, bus.RSP_VALID, bus.RSP_ERR, bus.RSP_DATA);
        end
        trst = 1'b0;
        last_known = 1'b1;
        last_exp   = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge tck);
            checks++;
            if (tms !== (i < 5) || tdo !== 1'b0) begin
                errors++;
                $display("FAIL reset_seq cyc%0d: tms=%b tdo=%b, need tms=%b tdo=0", i, tms, tdo, (i < 5));
            end
            checks++;
            if (bus.CMD_READY !== 1'b0 || bus.RSP_VALID !== 1'b0 || bus.BUSY !== 1'b1) begin
                errors++;
                $display("FAIL reset_busy cyc%0d: rdy=%b rv=%b busy=%b, need 0 0 1",
                         i, bus.CMD_READY, bus.RSP_VALID, bus.BUSY);
            end
        end
        @(negedge tck);
        checks++;
        if (bus.CMD_READY !== 1'b1 || bus.BUSY !== 1'b0 || bus.RSP_VALID !== 1'b0 || tms !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: rdy=%b busy=%b rv=%b tms=%b, need 1 0 0 0",
                     bus.CMD_READY, bus.BUSY, bus.RSP_VALID, tms);
        end
    endtask

    // Entered at a negedge; returns just after the accepting posedge.
    task automatic accept_cmd(input logic [1:0] t, input int n, input logic [63:0] d,
                              output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        while (bus.CMD_READY !== 1'b1 && waited < 200) begin
            @(negedge tck);
            waited++;
        end
        checks++;
        if (bus.CMD_READY !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: CMD_READY=%b after %0d cycles, need 1", bus.CMD_READY, waited);
            return;
        end
        bus.CMD_VALID = 1'b1;
        bus.CMD_TYPE  = t;
        bus.CMD_LEN   = n[LEN_W-1:0];
        bus.CMD_DATA  = d;
        @(posedge tck);
        #1;
        bus.CMD_VALID = 1'b0;
        bus.CMD_TYPE  = 2'($urandom);
        bus.CMD_LEN   = LEN_W'($urandom);
        bus.CMD_DATA  = {$urandom, $urandom};
        ok = 1'b1;
    endtask

    task automatic run_cmd(input logic [1:0] t, input int n, input logic [63:0] d,
                           input logic [63:0] tdi_bits, output int waited);
        bit          exp_tms[$];
        int          sh_start;
        bit          scan, err, ok, in_shift;
        logic        exp_tdo;
        logic [63:0] exp_data;
        sh_start = 0;
        scan = (t == 2'b01) || (t == 2'b10);
        err  = scan && ((n == 0) || (n > ((t == 2'b10) ? MAX_DR_LEN : MAX_IR_LEN)));
        if (t == 2'b00) begin
            repeat (5) exp_tms.push_back(1'b1);
            exp_tms.push_back(1'b0);
        end else if (t == 2'b11) begin
            repeat (n) exp_tms.push_back(1'b0);
        end else if (!err) begin
            exp_tms.push_back(1'b1);
            if (t == 2'b01) exp_tms.push_back(1'b1);
            exp_tms.push_back(1'b0);
            exp_tms.push_back(1'b0);
            sh_start = exp_tms.size();
            for (int k = 0; k < n; k++) exp_tms.push_back(k == n - 1);
            exp_tms.push_back(1'b1);
            exp_tms.push_back(1'b0);
        end
        if (err || !scan)  exp_data = 64'd0;
        else if (n >= 64)  exp_data = tdi_bits;
        else               exp_data = tdi_bits & ((64'd1 << n) - 64'd1);

        accept_cmd(t, n, d, ok, waited);
        if (!ok) return;
        foreach (exp_tms[i]) begin
            @(negedge tck);
            in_shift = scan && !err && (i >= sh_start) && (i < sh_start + n);
            if (in_shift) begin
                tdi     = tdi_bits[i - sh_start];
                exp_tdo = d[i - sh_start];
            end else begin
                tdi     = 1'($urandom);
                exp_tdo = 1'b0;
            end
            checks++;
            if (tms !== exp_tms[i]) begin
                errors++;
                $display("FAIL tms type%0d len%0d cyc%0d: got %b, need %b", t, n, i, tms, exp_tms[i]);
            end
            checks++;
            if (tdo !== exp_tdo) begin
                errors++;
                $display("FAIL tdo type%0d len%0d cyc%0d: got %b, need %b", t, n, i, tdo, exp_tdo);
            end
            checks++;
            if (bus.RSP_VALID !== 1'b0 || bus.CMD_READY !== 1'b0 || bus.BUSY !== 1'b1) begin
                errors++;
                $display("FAIL busy type%0d len%0d cyc%0d: rv=%b rdy=%b busy=%b, need 0 0 1",
                         t, n, i, bus.RSP_VALID, bus.CMD_READY, bus.BUSY);
            end
        end
        @(negedge tck);
        tdi = 1'($urandom);
        checks++;
        if (bus.RSP_VALID !== 1'b1 || bus.RSP_ERR !== err) begin
            errors++;
            $display("FAIL rsp type%0d len%0d: rv=%b err=%b, need rv=1 err=%b",
                     t, n, bus.RSP_VALID, bus.RSP_ERR, err);
        end
        if (scan) begin
            checks++;
            if (bus.RSP_DATA !== exp_data) begin
                errors++;
                $display("FAIL rsp_data type%0d len%0d: got %h, need %h", t, n, bus.RSP_DATA, exp_data);
            end
        end
        checks++;
        if (bus.CMD_READY !== 1'b1 || bus.BUSY !== 1'b0 || tms !== 1'b0 || tdo !== 1'b0) begin
            errors++;
            $display("FAIL rsp_pins type%0d len%0d: rdy=%b busy=%b tms=%b tdo=%b, need 1 0 0 0",
                     t, n, bus.CMD_READY, bus.BUSY, tms, tdo);
        end
        last_known = scan;
        last_exp   = exp_data;
    endtask

    task automatic idle_gap(input int cycles);
        for (int g = 0; g < cycles; g++) begin
            @(negedge tck);
            tdi = 1'($urandom);
            checks++;
            if (bus.RSP_VALID !== 1'b0 || tms !== 1'b0 || bus.CMD_READY !== 1'b1) begin
                errors++;
                $display("FAIL idle_gap cyc%0d: rv=%b tms=%b rdy=%b, need 0 0 1",
                         g, bus.RSP_VALID, tms, bus.CMD_READY);
            end
            if (last_known) begin
                checks++;
                if (bus.RSP_DATA !== last_exp) begin
                    errors++;
                    $display("FAIL rsp_hold cyc%0d: got %h, need %h", g, bus.RSP_DATA, last_exp);
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset(3);
    endtask

    task automatic test_ir_scan();
        int w;
        run_cmd(2'b01, 5, 64'h11, 64'h1, w);
        idle_gap(2);
    endtask

    task automatic test_dr_scan();
        int w;
        run_cmd(2'b10, 32, 64'hDEADBEEF, 64'h12345678, w);
        idle_gap(3);
    endtask

    task automatic test_back_to_back();
        int w;
        run_cmd(2'b10, 64, {$urandom, $urandom}, {$urandom, $urandom}, w);
        run_cmd(2'b10, 1, 64'h1, 64'h1, w);
        checks++;
        if (w !== 0) begin
            errors++;
            $display("FAIL back_to_back: waited %0d cycles for ready, need 0", w);
        end
        run_cmd(2'b01, 8, 64'hA5, 64'h3C, w);
        idle_gap(1);
    endtask

    task automatic test_errors();
        int w;
        run_cmd(2'b10, 0, 64'hFFFF, 64'hFFFF, w);
        run_cmd(2'b10, 65, 64'hFFFF, 64'hFFFF, w);
        run_cmd(2'b01, 9, 64'hFF, 64'hFF, w);
        run_cmd(2'b01, 0, 64'hFF, 64'hFF, w);
        idle_gap(2);
    endtask

    task automatic test_tap_and_idle();
        int w;
        run_cmd(2'b00, 0, 64'd0, 64'd0, w);
        run_cmd(2'b11, 0, 64'd0, 64'd0, w);
        run_cmd(2'b11, 3, 64'd0, 64'd0, w);
        idle_gap(1);
    endtask

    task automatic test_random();
        int          w, n;
        logic [1:0]  t;
        for (int r = 0; r < 30; r++) begin
            t = 2'($urandom_range(0, 3));
            case (t)
                2'b01:   n = $urandom_range(0, MAX_IR_LEN + 2);
                2'b10:   n = $urandom_range(0, MAX_DR_LEN + 2);
                2'b11:   n = $urandom_range(0, 5);
                default: n = 0;
            endcase
            run_cmd(t, n, {$urandom, $urandom}, {$urandom, $urandom}, w);
            idle_gap($urandom_range(0, 3));
        end
    endtask

    task automatic test_trst_mid();
        int w;
        bit ok;
        accept_cmd(2'b10, 32, 64'hCAFEF00D, ok, w);
        for (int i = 0; i < 10; i++) begin
            @(negedge tck);
            checks++;
            if (bus.RSP_VALID !== 1'b0) begin
                errors++;
                $display("FAIL trst_mid_rv cyc%0d: rv=%b, need 0", i, bus.RSP_VALID);
            end
        end
        do_reset(2);
        run_cmd(2'b01, 5, 64'h11, 64'h1, w);
        idle_gap(2);
    endtask

    initial begin
        bus.CMD_VALID = 1'b0;
        bus.CMD_TYPE  = 2'b00;
        bus.CMD_LEN   = '0;
        bus.CMD_DATA  = '0;
        test_reset();
        test_ir_scan();
        test_dr_scan();
        test_back_to_back();
        test_errors();
        test_tap_and_idle();
        test_random();
        test_trst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
